// File: rtl/rx_frame_ctrl_pkg.sv
// Shared RX symbol constants, framing FSM encodings and packet-type codes.
// Combinational helpers only; no latency.
// No flow control; used by the RX byte path and the framing controller.
package rx_frame_ctrl_pkg;

  // Physical-layer control symbols carried on the RX byte path
  localparam logic [7:0] SYM_STP_CODE = 8'hFB;
  localparam logic [7:0] SYM_SDP_CODE = 8'h5C;
  localparam logic [7:0] SYM_END_CODE = 8'hFD;
  localparam logic [7:0] SYM_IDL_CODE = 8'h7C;
  localparam logic [7:0] SYM_PAD_CODE = 8'hF7;

  // Packet type codes presented on PKT_TYPE
  localparam logic PKT_TLP  = 1'b0;
  localparam logic PKT_DLLP = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TLP  = 2'd1,
    ST_DLLP = 2'd2,
    ST_DROP = 2'd3
  } frame_state_t;

  // IDL and PAD behave identically for framing, so they share one class
  typedef enum logic [2:0] {
    SYM_DATA = 3'd0,
    SYM_STP  = 3'd1,
    SYM_SDP  = 3'd2,
    SYM_END  = 3'd3,
    SYM_FILL = 3'd4
  } sym_class_t;

  function automatic sym_class_t classify_sym(input logic [7:0] b);
    sym_class_t c;
    case (b)
      SYM_STP_CODE: c = SYM_STP;
      SYM_SDP_CODE: c = SYM_SDP;
      SYM_END_CODE: c = SYM_END;
      SYM_IDL_CODE: c = SYM_FILL;
      SYM_PAD_CODE: c = SYM_FILL;
      default:      c = SYM_DATA;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rx_byte_hold.sv
// One-byte hold stage with full/first flags so a packet's last byte can leave with EOP.
// Load/flush take effect on the next CLK edge; contents readable the cycle after load.
// No backpressure: load wins over flush, and with neither asserted the stage freezes.
module rx_byte_hold (
  input  logic       CLK,
  input  logic       RESET_L,
  input  logic       load,
  input  logic [7:0] load_dat,
  input  logic       flush,
  output logic [7:0] hold_dat,
  output logic       hold_full,
  output logic       hold_first
);

  // Capture a new byte (first only if the stage was empty) or drop the held one
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      hold_dat   <= 8'h00;
      hold_full  <= 1'b0;
      hold_first <= 1'b0;
    end else if (load) begin
      hold_dat   <= load_dat;
      hold_full  <= 1'b1;
      hold_first <= ~hold_full;
    end else if (flush) begin
      hold_full  <= 1'b0;
      hold_first <= 1'b0;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive framing controller: classifies RX symbols, frames TLP/DLLP packets, flags errors.
// Data byte appears one cycle after the next valid symbol following it is sampled.
// No backpressure downstream; RX_VALID=0 freezes all state and drops the strobes.
module rx_frame_ctrl
  import rx_frame_ctrl_pkg::*;
#(
  parameter int MAX_TLP_LEN = 64,
  parameter int DLLP_LEN    = 6,
  parameter int LEN_W       = 8
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic [7:0]       RX_BYTE,
  input  logic             RX_VALID,
  output logic [7:0]       DATA_OUT,
  output logic             VALID_OUT,
  output logic             SOP,
  output logic             EOP,
  output logic             PKT_TYPE,
  output logic [LEN_W-1:0] PKT_LEN,
  output logic             ERR,
  output logic [7:0]       ERR_CNT
);

  localparam logic [LEN_W-1:0] MAX_LEN_L  = LEN_W'(MAX_TLP_LEN);
  localparam logic [LEN_W-1:0] DLLP_LEN_L = LEN_W'(DLLP_LEN);

  frame_state_t     state, nxt_state;
  logic [LEN_W-1:0] cnt, nxt_cnt;
  logic             cur_type, nxt_type;
  sym_class_t       sym;

  logic             emit, emit_eop, err_set;
  logic             hold_load, hold_flush;
  logic [7:0]       hold_dat;
  logic             hold_full, hold_first;

  rx_byte_hold u_hold (
    .CLK        (CLK),
    .RESET_L    (RESET_L),
    .load       (hold_load),
    .load_dat   (RX_BYTE),
    .flush      (hold_flush),
    .hold_dat   (hold_dat),
    .hold_full  (hold_full),
    .hold_first (hold_first)
  );

  // Next-state, hold-stage control and error decisions for the sampled symbol
  always_comb begin
    sym        = classify_sym(RX_BYTE);
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_type   = cur_type;
    emit       = 1'b0;
    emit_eop   = 1'b0;
    err_set    = 1'b0;
    hold_load  = 1'b0;
    hold_flush = 1'b0;

    if (RX_VALID) begin
      case (state)
        ST_IDLE: begin
          case (sym)
            SYM_STP: begin
              nxt_state = ST_TLP;
              nxt_cnt   = '0;
              nxt_type  = PKT_TLP;
            end
            SYM_SDP: begin
              nxt_state = ST_DLLP;
              nxt_cnt   = '0;
              nxt_type  = PKT_DLLP;
            end
            SYM_DATA, SYM_END: err_set = 1'b1;
            default: ;
          endcase
        end

        ST_TLP, ST_DLLP: begin
          // Any symbol inside a packet pushes out whatever byte is held
          emit = hold_full;
          case (sym)
            SYM_DATA: begin
              if (state == ST_TLP && cnt == MAX_LEN_L) begin
                // Overflow: close the packet on the held byte, discard the newcomer
                emit_eop   = 1'b1;
                err_set    = 1'b1;
                hold_flush = 1'b1;
                nxt_state  = ST_DROP;
              end else begin
                hold_load = 1'b1;
                if (cnt != '1) nxt_cnt = cnt + 1'b1;
              end
            end
            SYM_END: begin
              emit_eop   = 1'b1;
              hold_flush = 1'b1;
              nxt_state  = ST_IDLE;
              if (!hold_full)
                err_set = 1'b1;
              else if (state == ST_DLLP && cnt != DLLP_LEN_L)
                err_set = 1'b1;
            end
            SYM_STP, SYM_SDP: begin
              // Missing END: close the old packet and open the new one together
              emit_eop   = 1'b1;
              err_set    = 1'b1;
              hold_flush = 1'b1;
              nxt_state  = (sym == SYM_STP) ? ST_TLP : ST_DLLP;
              nxt_cnt    = '0;
              nxt_type   = (sym == SYM_STP) ? PKT_TLP : PKT_DLLP;
            end
            default: begin
              emit_eop   = 1'b1;
              err_set    = 1'b1;
              hold_flush = 1'b1;
              nxt_state  = ST_IDLE;
            end
          endcase
        end

        default: begin
          // DROP: silently discard until END; a new start symbol is accepted as-is
          case (sym)
            SYM_END: nxt_state = ST_IDLE;
            SYM_STP: begin
              nxt_state = ST_TLP;
              nxt_cnt   = '0;
              nxt_type  = PKT_TLP;
            end
            SYM_SDP: begin
              nxt_state = ST_DLLP;
              nxt_cnt   = '0;
              nxt_type  = PKT_DLLP;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  // Framing FSM, byte counter and registered packet/error outputs
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cur_type  <= PKT_TLP;
      DATA_OUT  <= 8'h00;
      VALID_OUT <= 1'b0;
      SOP       <= 1'b0;
      EOP       <= 1'b0;
      PKT_TYPE  <= 1'b0;
      PKT_LEN   <= '0;
      ERR       <= 1'b0;
      ERR_CNT   <= 8'h00;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      cur_type  <= nxt_type;
      VALID_OUT <= emit;
      SOP       <= emit & hold_first;
      EOP       <= emit & emit_eop;
      ERR       <= err_set;
      // PKT_TYPE follows the packet being emitted, not the one just opened
      if (emit) begin
        DATA_OUT <= hold_dat;
        PKT_TYPE <= cur_type;
      end
      if (emit && emit_eop) PKT_LEN <= cnt;
      if (err_set && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Self-checking bench for rx_frame_ctrl: scoreboard of expected output bytes plus error counts.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Each scenario starts from reset so the error counter is absolute.
module tb_rx_frame_ctrl;

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_IDL = 8'h7C;
  localparam logic [7:0] K_PAD = 8'hF7;

  logic       CLK = 1'b0;
  logic       RESET_L = 1'b0;
  logic [7:0] RX_BYTE = 8'h00;
  logic       RX_VALID = 1'b0;
  logic [7:0] DATA_OUT;
  logic       VALID_OUT, SOP, EOP, PKT_TYPE, ERR;
  logic [7:0] PKT_LEN;
  logic [7:0] ERR_CNT;

  always #5 CLK = ~CLK;

  rx_frame_ctrl #(.MAX_TLP_LEN(64), .DLLP_LEN(6), .LEN_W(8)) dut (
    .CLK       (CLK),
    .RESET_L   (RESET_L),
    .RX_BYTE   (RX_BYTE),
    .RX_VALID  (RX_VALID),
    .DATA_OUT  (DATA_OUT),
    .VALID_OUT (VALID_OUT),
    .SOP       (SOP),
    .EOP       (EOP),
    .PKT_TYPE  (PKT_TYPE),
    .PKT_LEN   (PKT_LEN),
    .ERR       (ERR),
    .ERR_CNT   (ERR_CNT)
  );

  typedef struct {
    logic [7:0] dat;
    logic       sop;
    logic       eop;
    logic       typ;
    logic [7:0] len;
    logic       err;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   err_seen = 0;
  int   err_base = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] dat, input logic sop, input logic eop,
                      input logic typ, input logic [7:0] len, input logic err);
    exp_t x;
    x.dat = dat; x.sop = sop; x.eop = eop; x.typ = typ; x.len = len; x.err = err;
    q.push_back(x);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    RX_BYTE  = b;
    RX_VALID = 1'b1;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge CLK);
      RX_VALID = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RX_VALID = 1'b0;
    RESET_L  = 1'b0;
    @(negedge CLK);
    RESET_L  = 1'b1;
    chk("rst_outs", 32'({DATA_OUT, PKT_LEN, ERR_CNT, VALID_OUT, SOP, EOP, ERR, PKT_TYPE}), 32'd0);
    err_base = err_seen;
  endtask

  task automatic finish_scn(input string tag, input int exp_err);
    gap(4);
    chk({tag, "_drain"}, 32'(q.size()), 32'd0);
    q.delete();
    chk({tag, "_errs"}, 32'(err_seen - err_base), 32'(exp_err));
    chk({tag, "_errcnt"}, 32'(ERR_CNT), 32'((exp_err > 255) ? 255 : exp_err));
  endtask

  // Output monitor: every emitted byte must match the head of the scoreboard
  always @(negedge CLK) begin
    if (ERR === 1'b1) err_seen++;
    if (VALID_OUT === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_vld", 32'(VALID_OUT), 32'd0);
      end else begin
        e = q.pop_front();
        chk("dat", 32'(DATA_OUT), 32'(e.dat));
        chk("sop", 32'(SOP), 32'(e.sop));
        chk("eop", 32'(EOP), 32'(e.eop));
        chk("type", 32'(PKT_TYPE), 32'(e.typ));
        chk("err_w_dat", 32'(ERR), 32'(e.err));
        if (e.eop) chk("len", 32'(PKT_LEN), 32'(e.len));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Basic TLP with surrounding idles
    do_reset();
    push(8'h11, 1, 0, 0, 0, 0);
    push(8'h22, 0, 0, 0, 0, 0);
    push(8'h33, 0, 1, 0, 3, 0);
    send(K_IDL); send(K_STP); send(8'h11); send(8'h22); send(8'h33); send(K_END); send(K_IDL);
    finish_scn("tlp3", 0);

    // DLLP with correct length, then one byte short
    do_reset();
    for (int i = 1; i <= 6; i++) push(8'(i), i == 1, i == 6, 1, 6, 0);
    send(K_SDP);
    for (int i = 1; i <= 6; i++) send(8'(i));
    send(K_END);
    finish_scn("dllp6", 0);
    for (int i = 1; i <= 5; i++) push(8'(8'h20 + i), i == 1, i == 5, 1, 5, i == 5);
    send(K_SDP);
    for (int i = 1; i <= 5; i++) send(8'(8'h20 + i));
    send(K_END);
    finish_scn("dllp5", 1);

    // TLP interrupted by SDP, DLLP follows intact
    do_reset();
    push(8'hAA, 1, 0, 0, 0, 0);
    push(8'hBB, 0, 1, 0, 2, 1);
    for (int i = 1; i <= 6; i++) push(8'(8'hC0 + i), i == 1, i == 6, 1, 6, 0);
    send(K_STP); send(8'hAA); send(8'hBB); send(K_SDP);
    for (int i = 1; i <= 6; i++) send(8'(8'hC0 + i));
    send(K_END);
    finish_scn("nested", 1);

    // TLP overflow, tail dropped, then a normal 1-byte packet
    do_reset();
    for (int i = 1; i <= 64; i++) push(8'(i), i == 1, i == 64, 0, 64, i == 64);
    push(8'h33, 1, 1, 0, 1, 0);
    send(K_STP);
    for (int i = 1; i <= 68; i++) send(8'(i));
    send(K_END);
    send(K_STP); send(8'h33); send(K_END);
    finish_scn("ovf", 1);

    // Empty packets: error only, counter saturates
    do_reset();
    repeat (300) begin
      send(K_STP);
      send(K_END);
    end
    finish_scn("empty", 300);

    // Gaps freeze the stage, reset discards the held byte
    do_reset();
    push(8'h11, 1, 0, 0, 0, 0);
    send(K_STP); send(8'h11); gap(3); send(8'h22); gap(3);
    chk("gap_q", 32'(q.size()), 32'd0);
    do_reset();
    push(8'h33, 1, 1, 0, 1, 0);
    send(K_STP); send(8'h33); send(K_END);
    finish_scn("rst", 0);

    // Idle-state data/END errors, fill symbols ignored, PAD aborts a DLLP
    do_reset();
    push(8'h01, 1, 0, 1, 0, 0);
    push(8'h02, 0, 1, 1, 2, 1);
    send(8'h42); send(K_PAD); send(K_IDL);
    send(K_SDP); send(8'h01); send(8'h02); send(K_PAD); send(K_END);
    finish_scn("misc", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
Receive-side framing controller that sits directly behind the physical-layer byte path and sequences it into packets. It classifies each valid received byte as a control symbol (STP, SDP, END, IDL, PAD) or data, and runs a framing FSM. Data bytes are emitted through a one-byte hold stage, so the last byte of a packet leaves together with its EOP flag. Framing errors are detected, flagged and counted, and the link layer above sees clean SOP/EOP-delimited TLP and DLLP streams.

Parameters:
MAX_TLP_LEN, 64, maximum TLP data bytes between STP and END; byte MAX_TLP_LEN+1 is an overflow error
DLLP_LEN, 6, exact required DLLP data byte count between SDP and END
LEN_W, 8, width of PKT_LEN; must hold MAX_TLP_LEN+1

Ports:
CLK  input  1  rising-edge clock
RESET_L  input  1  synchronous active-low reset
RX_BYTE  input  8  received byte/symbol
RX_VALID  input  1  RX_BYTE valid this cycle
DATA_OUT  output  8  packet data byte
VALID_OUT  output  1  DATA_OUT valid (single-cycle per byte)
SOP  output  1  first byte of packet (qualified by VALID_OUT)
EOP  output  1  last byte of packet (qualified by VALID_OUT)
PKT_TYPE  output  1  0=TLP, 1=DLLP; stable from SOP through EOP
PKT_LEN  output  LEN_W  data byte count; valid when EOP=1
ERR  output  1  one-cycle framing-error pulse (may assert with VALID_OUT=0)
ERR_CNT  output  8  saturating error count (stops at 255)

Behaviour:
- Clock is CLK. Reset is synchronous and active-low on RESET_L.
- Reset: all outputs 0, FSM=IDLE, hold register empty, byte counter 0. Reset mid-packet discards the held byte with no EOP.
- All outputs are registered. RX_VALID=0: FSM, hold stage and counters freeze; VALID_OUT/ERR/SOP/EOP go 0 next cycle.
- Symbol constants: STP=8'hFB, SDP=8'h5C, END=8'hFD, IDL=8'h7C, PAD=8'hF7. Any other value is data.
- FSM states: IDLE, TLP, DLLP, DROP.
- IDLE:
  - STP -> TLP, counter=0, PKT_TYPE=0.
  - SDP -> DLLP, counter=0, PKT_TYPE=1.
  - IDL/PAD ignored.
  - Data or END -> ERR pulse, stay IDLE.
- TLP/DLLP, data byte:
  - If hold is empty, load the byte and mark it first.
  - Otherwise emit the held byte (VALID_OUT=1, SOP=first flag, EOP=0) and load the new byte.
  - Counter increments per data byte.
- TLP/DLLP, END with hold full: emit held byte with EOP=1 and PKT_LEN=counter, then go IDLE.
  - If DLLP and counter!=DLLP_LEN, ERR=1 in the same cycle as EOP.
- END with hold empty (empty packet): ERR pulse, no VALID_OUT, go IDLE.
- TLP/DLLP, STP or SDP (missing END):
  - Emit held byte (if any) with EOP=1 and ERR=1.
  - Start the new packet per the IDLE rules in the same cycle.
- TLP/DLLP, IDL or PAD: emit held byte (if any) with EOP=1 and ERR=1, go IDLE.
- TLP overflow, i.e. data byte while counter==MAX_TLP_LEN: emit held byte with EOP=1, ERR=1 and PKT_LEN=MAX_TLP_LEN, discard the new byte, go DROP.
- DROP:
  - Discard everything until END, then go IDLE with no error.
  - STP/SDP start a new packet with no additional ERR.
- Latency: a data byte appears on DATA_OUT one cycle after the next valid symbol following it is sampled.
- ERR_CNT increments once per ERR pulse and saturates at 255.
- SOP and EOP may both be 1 for a 1-byte packet.

Decomposition:
- Shared define/package rx_symbols: STP/SDP/END/IDL/PAD constants, FSM state encodings, PKT_TYPE codes. The same constants are used by the existing RX byte path.
- One sub-module, rx_byte_hold: the one-byte hold register with full and first flags and load/emit/flush controls.
- The FSM, counters and error logic stay in rx_frame_ctrl.

Test Plan:
- IDL,STP,11,22,33,END,IDL -> VALID_OUT at 11(SOP),22,33(EOP); PKT_LEN=3, PKT_TYPE=0, ERR never set.
- SDP, 6 data bytes, END -> 6 outputs, SOP on first, EOP on sixth, PKT_TYPE=1, PKT_LEN=6, no ERR. Repeat with 5 bytes -> same framing but ERR=1 with EOP, ERR_CNT=1.
- STP,AA,BB,SDP,C1..C6,END -> BB emitted with EOP+ERR; DLLP C1..C6 follows intact; ERR_CNT=1.
- STP, 65 data bytes, then 3 data, END (MAX_TLP_LEN=64) -> 64 bytes out, EOP+ERR on 64th, PKT_LEN=64; remaining bytes and END dropped silently; FSM back in IDLE.
- STP,END -> ERR pulse, no VALID_OUT. 300 such errors -> ERR_CNT holds at 255.
- STP,11,22 with RX_VALID low for 3 cycles between, then RESET_L=0 for one cycle -> no outputs during the gaps; after reset all outputs 0 and a following STP,33,END yields a single byte with SOP=EOP=1.
